// File: rtl/vend_pkg.sv
// Shared types, coin encodings and default price table for the vending controller.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] COIN_NICKEL  = 2'b00;
  localparam logic [1:0] COIN_DIME    = 2'b01;
  localparam logic [1:0] COIN_QUARTER = 2'b10;
  localparam logic [1:0] COIN_DOLLAR  = 2'b11;

  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;
  localparam int unsigned VAL_DOLLAR  = 100;

  localparam int unsigned N_PRICES = 8;
  localparam int unsigned PIDX_W   = $clog2(N_PRICES);
  localparam int unsigned PRICE [N_PRICES] = '{50, 80, 100, 120, 150, 60, 90, 200};

  // Inserted-coin value; code 00 is not a valid inserted coin and is worth nothing.
  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_DIME:    return VAL_DIME;
      COIN_QUARTER: return VAL_QUARTER;
      COIN_DOLLAR:  return VAL_DOLLAR;
      default:      return 0;
    endcase
  endfunction

  function automatic int unsigned price_of(input int unsigned code);
    int unsigned p;
    p = 0;
    for (int i = 0; i < int'(N_PRICES); i++)
      if (code == 32'(i + 1)) p = PRICE[PIDX_W'(i)];
    return p;
  endfunction

  function automatic bit prices_fit(input int unsigned amt_w, input int unsigned max_qty);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < int'(N_PRICES); i++)
      if (longint'(PRICE[PIDX_W'(i)]) * longint'(max_qty) >= (longint'(1) << amt_w)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/vend_change_disp.sv
// Greedy change dispenser: loads an amount and pays it out one coin per cycle, largest first.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [AMT_W-1:0] amount,
  output logic             coin_valid,
  output logic [1:0]       coin,
  output logic             idle_c
);

  logic [AMT_W-1:0] remaining;
  logic [1:0]       pick_c;
  logic [AMT_W-1:0] pick_val_c;

  always_comb begin
    pick_c     = COIN_NICKEL;
    pick_val_c = AMT_W'(VAL_NICKEL);
    if (remaining >= AMT_W'(VAL_DOLLAR)) begin
      pick_c     = COIN_DOLLAR;
      pick_val_c = AMT_W'(VAL_DOLLAR);
    end else if (remaining >= AMT_W'(VAL_QUARTER)) begin
      pick_c     = COIN_QUARTER;
      pick_val_c = AMT_W'(VAL_QUARTER);
    end else if (remaining >= AMT_W'(VAL_DIME)) begin
      pick_c     = COIN_DIME;
      pick_val_c = AMT_W'(VAL_DIME);
    end
  end

  assign idle_c = (remaining == '0) && !load;

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining  <= '0;
      coin_valid <= 1'b0;
      coin       <= COIN_NICKEL;
    end else begin
      coin_valid <= 1'b0;
      if (load) begin
        remaining <= amount;
      end else if (remaining >= AMT_W'(VAL_NICKEL)) begin
        coin_valid <= 1'b1;
        coin       <= pick_c;
        remaining  <= remaining - pick_val_c;
      end else begin
        // Sub-nickel residue cannot be paid; drop it rather than hang.
        remaining <= '0;
      end
    end
  end

endmodule

// File: rtl/vend_ctrl_v3.sv
// Vending-machine controller: credit collection, per-item stock, delivery and greedy change/refund.
module vend_ctrl_v3
  import vend_pkg::*;
#(
  parameter int unsigned N_ITEMS    = 8,
  parameter int unsigned AMT_W      = 12,
  parameter int unsigned QTY_W      = 2,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 4,
  parameter int unsigned MAX_CREDIT = 500,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cancel,
  input  logic                           cont,
  input  logic [$clog2(N_ITEMS+1)-1:0]   item_sel,
  input  logic [QTY_W-1:0]               qty_sel,
  input  logic                           coin_valid,
  input  logic [1:0]                     coin_type,
  input  logic                           restock,
  output logic [2:0]                     state,
  output logic [AMT_W-1:0]               collected,
  output logic [AMT_W-1:0]               price_due,
  output logic                           deliver_valid,
  output logic [$clog2(N_ITEMS+1)-1:0]   deliver_item,
  output logic [QTY_W-1:0]               deliver_qty,
  output logic                           change_valid,
  output logic [1:0]                     change_coin,
  output logic                           coin_reject,
  output logic                           sold_out,
  output logic                           timeout_flag
);

  localparam int unsigned IW    = $clog2(N_ITEMS + 1);
  localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CW    = (QTY_W > STOCK_W) ? QTY_W : STOCK_W;

  if (!prices_fit(AMT_W, (1 << QTY_W) - 1)) begin : g_price_overflow
    $error("price * max quantity does not fit in AMT_W");
  end

  state_t             fsm;
  logic [IW-1:0]      item;
  logic [QTY_W-1:0]   qty;
  logic [STOCK_W-1:0] stock [N_ITEMS];
  logic [CNT_W-1:0]   idle_cnt;
  logic               after_buy;
  logic               chg_load;
  logic [AMT_W-1:0]   chg_amt;
  logic               disp_idle_c;

  logic [AMT_W-1:0]   coin_val_c, credit_c, sel_price_c, col_price_c;
  logic [AMT_W:0]     sum_c;
  logic               accept_c, reject_c, sel_ok_c, timeout_hit_c;
  logic [STOCK_W-1:0] sel_stock_c, item_stock_c;
  logic [QTY_W-1:0]   sel_qty_c, col_qty_c;

  assign state = fsm;

  // Requested quantity (0 means 1) limited to what is in stock.
  function automatic logic [QTY_W-1:0] clamp_qty(input logic [QTY_W-1:0] req,
                                                 input logic [STOCK_W-1:0] stk);
    logic [QTY_W-1:0] r;
    r = (req == '0) ? QTY_W'(1) : req;
    if (CW'(r) > CW'(stk)) r = QTY_W'(stk);
    return r;
  endfunction

  always_comb begin
    coin_val_c   = AMT_W'(coin_value(coin_type));
    sum_c        = (AMT_W+1)'(collected) + (AMT_W+1)'(coin_val_c);
    accept_c     = coin_valid && (coin_val_c != '0) &&
                   ((fsm == S_IDLE) || (fsm == S_COLLECT)) &&
                   (sum_c <= (AMT_W+1)'(MAX_CREDIT));
    reject_c     = coin_valid && (coin_val_c != '0) && !accept_c;
    credit_c     = accept_c ? AMT_W'(sum_c) : collected;
    sel_ok_c     = (item_sel != '0) && (int'(item_sel) <= int'(N_ITEMS));
    sel_stock_c  = '0;
    item_stock_c = '0;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (int'(item_sel) == i + 1) sel_stock_c = stock[SEL_W'(i)];
      if (int'(item) == i + 1)     item_stock_c = stock[SEL_W'(i)];
    end
    sel_qty_c     = clamp_qty(qty_sel, sel_stock_c);
    sel_price_c   = AMT_W'(price_of(32'(item_sel))) * AMT_W'(sel_qty_c);
    col_qty_c     = (qty_sel != '0) ? clamp_qty(qty_sel, item_stock_c) : qty;
    col_price_c   = AMT_W'(price_of(32'(item))) * AMT_W'(col_qty_c);
    timeout_hit_c = (idle_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm           <= S_IDLE;
      collected     <= '0;
      price_due     <= '0;
      item          <= '0;
      qty           <= '0;
      idle_cnt      <= '0;
      after_buy     <= 1'b0;
      chg_load      <= 1'b0;
      chg_amt       <= '0;
      deliver_valid <= 1'b0;
      deliver_item  <= '0;
      deliver_qty   <= '0;
      coin_reject   <= 1'b0;
      sold_out      <= 1'b0;
      timeout_flag  <= 1'b0;
      for (int i = 0; i < int'(N_ITEMS); i++) stock[SEL_W'(i)] <= STOCK_W'(STOCK_INIT);
    end else begin
      deliver_valid <= 1'b0;
      coin_reject   <= reject_c;
      sold_out      <= 1'b0;
      timeout_flag  <= 1'b0;
      chg_load      <= 1'b0;
      collected     <= credit_c;
      case (fsm)
        S_IDLE: begin
          if (restock)
            for (int i = 0; i < int'(N_ITEMS); i++) stock[SEL_W'(i)] <= STOCK_W'(STOCK_INIT);
          if (cancel && (credit_c != '0)) begin
            collected <= '0;
            chg_amt   <= credit_c;
            chg_load  <= 1'b1;
            after_buy <= 1'b0;
            fsm       <= S_CHANGE;
          end else if (sel_ok_c) begin
            if (sel_stock_c == '0) begin
              sold_out <= 1'b1;
            end else begin
              item      <= item_sel;
              qty       <= sel_qty_c;
              price_due <= sel_price_c;
              idle_cnt  <= '0;
              fsm       <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          qty       <= col_qty_c;
          price_due <= col_price_c;
          if (accept_c)           idle_cnt <= '0;
          else if (!timeout_hit_c) idle_cnt <= idle_cnt + CNT_W'(1);
          if (collected >= col_price_c) begin
            deliver_valid <= 1'b1;
            deliver_item  <= item;
            deliver_qty   <= col_qty_c;
            fsm           <= S_VEND;
          end else if (cancel || (timeout_hit_c && !accept_c)) begin
            // Refund path shared by cancel and inactivity timeout.
            timeout_flag <= !cancel;
            collected    <= '0;
            price_due    <= '0;
            item         <= '0;
            after_buy    <= 1'b0;
            if (credit_c != '0) begin
              chg_amt  <= credit_c;
              chg_load <= 1'b1;
              fsm      <= S_CHANGE;
            end else begin
              fsm <= S_IDLE;
            end
          end
        end
        S_VEND: begin
          for (int i = 0; i < int'(N_ITEMS); i++)
            if (int'(item) == i + 1) stock[SEL_W'(i)] <= stock[SEL_W'(i)] - STOCK_W'(qty);
          collected <= '0;
          chg_amt   <= collected - price_due;
          after_buy <= 1'b1;
          if (collected != price_due) begin
            chg_load <= 1'b1;
            fsm      <= S_CHANGE;
          end else begin
            fsm <= S_DONE;
          end
        end
        S_CHANGE: begin
          if (disp_idle_c) begin
            chg_amt <= '0;
            fsm     <= after_buy ? S_DONE : S_IDLE;
          end
        end
        S_DONE: begin
          if (cont) begin
            price_due <= '0;
            item      <= '0;
            after_buy <= 1'b0;
            fsm       <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  vend_change_disp #(.AMT_W(AMT_W)) u_disp (
    .clk        (clk),
    .rst        (rst),
    .load       (chg_load),
    .amount     (chg_amt),
    .coin_valid (change_valid),
    .coin       (change_coin),
    .idle_c     (disp_idle_c)
  );

endmodule

// File: tb/tb_vend_ctrl_v3.sv
// Scoreboard bench for vend_ctrl_v3: expected pulses queued at stimulus time, checked as they appear.
module tb_vend_ctrl_v3;

  localparam int TIMEOUT = 1000;
  localparam int EV_DEL  = 1 * 65536;
  localparam int EV_CHG  = 2 * 65536;
  localparam int EV_REJ  = 3 * 65536;
  localparam int EV_SOLD = 4 * 65536;
  localparam int EV_TMO  = 5 * 65536;
  localparam logic [1:0] C_NICKEL = 2'b00, C_DIME = 2'b01, C_QUARTER = 2'b10, C_DOLLAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst, cancel, cont, coin_valid, restock;
  logic [3:0]  item_sel;
  logic [1:0]  qty_sel, coin_type;
  logic [2:0]  state;
  logic [11:0] collected, price_due;
  logic        deliver_valid;
  logic [3:0]  deliver_item;
  logic [1:0]  deliver_qty;
  logic        change_valid;
  logic [1:0]  change_coin;
  logic        coin_reject, sold_out, timeout_flag;

  int nvec = 0;
  int nerr = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  vend_ctrl_v3 dut (
    .clk(clk), .rst(rst), .cancel(cancel), .cont(cont),
    .item_sel(item_sel), .qty_sel(qty_sel), .coin_valid(coin_valid),
    .coin_type(coin_type), .restock(restock), .state(state),
    .collected(collected), .price_due(price_due), .deliver_valid(deliver_valid),
    .deliver_item(deliver_item), .deliver_qty(deliver_qty),
    .change_valid(change_valid), .change_coin(change_coin),
    .coin_reject(coin_reject), .sold_out(sold_out), .timeout_flag(timeout_flag)
  );

  task automatic check(input string tag, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic observe(input string tag, input int ev);
    int want;
    want = -1;
    if (exp_q.size() > 0) want = exp_q.pop_front();
    check(tag, ev, want);
  endtask

  // Every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (deliver_valid === 1'b1) observe("deliver", EV_DEL + int'(deliver_item) * 16 + int'(deliver_qty));
    if (change_valid === 1'b1)  observe("change", EV_CHG + int'(change_coin));
    if (coin_reject === 1'b1)   observe("coin_reject", EV_REJ);
    if (sold_out === 1'b1)      observe("sold_out", EV_SOLD);
    if (timeout_flag === 1'b1)  observe("timeout_flag", EV_TMO);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
    coin_type  = 2'b00;
  endtask

  task automatic select(input int it, input int q);
    item_sel = 4'(it);
    qty_sel  = 2'(q);
    tick();
    item_sel = 4'd0;
  endtask

  task automatic pulse_cancel();
    qty_sel = 2'd0;
    cancel  = 1'b1;
    tick();
    cancel  = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    int n;
    n = 0;
    while (int'(state) != s && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(state), s);
  endtask

  task automatic leave_done();
    cont = 1'b1;
    tick();
    cont = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; cancel = 1'b0; cont = 1'b0; coin_valid = 1'b0; restock = 1'b0;
    item_sel = 4'd0; qty_sel = 2'd0; coin_type = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_state", int'(state), 0);
    check("reset_collected", int'(collected), 0);
    check("reset_price_due", int'(price_due), 0);

    // Buy item 2 (80c) with 85c: one nickel back.
    select(2, 0);
    check("t1_state", int'(state), 1);
    check("t1_price", int'(price_due), 80);
    exp_q.push_back(EV_DEL + 2 * 16 + 1);
    exp_q.push_back(EV_CHG + int'(C_NICKEL));
    repeat (3) put_coin(C_QUARTER);
    put_coin(C_DIME);
    check("t1_collected", int'(collected), 85);
    wait_state("t1_done", 4, 20);
    leave_done();
    check("t1_idle", int'(state), 0);
    check("t1_price_clr", int'(price_due), 0);
    select(2, 3);
    check("t1_stock2_is_3", int'(price_due), 240);
    pulse_cancel();
    check("t1_zero_refund_idle", int'(state), 0);

    // Cancel with 35c credit: quarter then dime refunded.
    select(1, 0);
    exp_q.push_back(EV_CHG + int'(C_QUARTER));
    exp_q.push_back(EV_CHG + int'(C_DIME));
    put_coin(C_QUARTER);
    put_coin(C_DIME);
    check("t2_collected", int'(collected), 35);
    pulse_cancel();
    check("t2_change_state", int'(state), 3);
    check("t2_collected_clr", int'(collected), 0);
    wait_state("t2_idle", 0, 20);

    // Item 5 qty 2 at exact price: no change.
    select(5, 2);
    check("t3_price", int'(price_due), 300);
    exp_q.push_back(EV_DEL + 5 * 16 + 2);
    repeat (3) put_coin(C_DOLLAR);
    wait_state("t3_done", 4, 10);
    leave_done();
    select(5, 3);
    check("t3_stock5_is_2", int'(price_due), 300);
    pulse_cancel();
    check("t3_idle", int'(state), 0);

    // Credit cap: 500 accepted, a further dime rejected.
    repeat (5) put_coin(C_DOLLAR);
    check("t4_cap", int'(collected), 500);
    exp_q.push_back(EV_REJ);
    put_coin(C_DIME);
    check("t4_cap_hold", int'(collected), 500);
    repeat (5) exp_q.push_back(EV_CHG + int'(C_DOLLAR));
    pulse_cancel();
    wait_state("t4_idle", 0, 30);

    // Exhaust item 3, then sold out, then restock.
    for (int k = 0; k < 4; k++) begin
      select(3, 0);
      exp_q.push_back(EV_DEL + 3 * 16 + 1);
      put_coin(C_DOLLAR);
      wait_state("t5_done", 4, 10);
      leave_done();
    end
    exp_q.push_back(EV_SOLD);
    select(3, 0);
    check("t5_sold_idle", int'(state), 0);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    select(3, 3);
    check("t5_restocked", int'(price_due), 300);
    pulse_cancel();

    // Inactivity timeout refunds the dime.
    select(8, 0);
    check("t6_price", int'(price_due), 200);
    exp_q.push_back(EV_TMO);
    exp_q.push_back(EV_CHG + int'(C_DIME));
    put_coin(C_DIME);
    n = 0;
    while (n < TIMEOUT + 20) begin
      tick();
      n++;
      if (timeout_flag === 1'b1) break;
    end
    check("t6_timeout_latency", n, TIMEOUT);
    wait_state("t6_idle", 0, 20);

    // Reset in the middle of a refund drops remaining change.
    put_coin(C_DOLLAR);
    put_coin(C_DOLLAR);
    put_coin(C_QUARTER);
    put_coin(C_DIME);
    exp_q.push_back(EV_CHG + int'(C_DOLLAR));
    pulse_cancel();
    tick();
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_rst_state", int'(state), 0);
    check("t7_rst_collected", int'(collected), 0);
    repeat (10) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_v3.md
Name: vend_ctrl_v3

Overview:
Parametrised vending-machine controller for N_ITEMS products, each with its own price and stock counter.
- Coins arrive as registered, single-cycle pulses; the block accumulates credit, checks stock and quantity, and emits a one-cycle delivery pulse.
- Change or refunds are paid one coin per cycle (dollar, quarter, dime, nickel), largest first.
- Adds synchronous reset, stock tracking, credit cap, coin rejection and an inactivity timeout.

Parameters:
N_ITEMS, 8, number of products; item codes 1..N_ITEMS, code 0 = none
AMT_W, 12, width of all cent quantities
QTY_W, 2, width of quantity select; max quantity 2^QTY_W-1
STOCK_W, 4, width of per-item stock counter
STOCK_INIT, 4, stock loaded into every item at reset and on restock
MAX_CREDIT, 500, credit cap in cents
TIMEOUT, 1000, idle cycles in COLLECT before auto-refund

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cancel  in  1  level; abort transaction, refund credit
cont  in  1  level; leave DONE
item_sel  in  $clog2(N_ITEMS+1)  item code, sampled in IDLE
qty_sel  in  QTY_W  quantity, 0 means 1
coin_valid  in  1  one-cycle coin pulse
coin_type  in  2  01 dime, 10 quarter, 11 dollar, 00 ignored
restock  in  1  reload all stock to STOCK_INIT (IDLE only)
state  out  3  current FSM state
collected  out  AMT_W  current credit
price_due  out  AMT_W  price*qty of the current selection
deliver_valid  out  1  one-cycle pulse
deliver_item  out  $clog2(N_ITEMS+1)  valid with deliver_valid
deliver_qty  out  QTY_W  valid with deliver_valid
change_valid  out  1  one pulse per returned coin
change_coin  out  2  00 nickel, 01 dime, 10 quarter, 11 dollar
coin_reject  out  1  one-cycle pulse; inserted coin returned, not credited
sold_out  out  1  one-cycle pulse; selection refused because stock is 0
timeout_flag  out  1  one-cycle pulse on auto-refund

Behaviour:
- Reset (synchronous, checked before everything else):
  - state=IDLE; collected, price_due, change register = 0.
  - All pulse outputs 0; all stock = STOCK_INIT.
  - Reset mid-CHANGE drops the remaining change with no further pulses.
- States: IDLE=0, COLLECT=1, VEND=2, CHANGE=3, DONE=4.
- Coin credit:
  - Credited in IDLE and COLLECT only, one cycle after coin_valid: collected += value.
  - The coin is rejected (coin_reject next cycle, credit unchanged) if collected+value > MAX_CREDIT, or if state is VEND, CHANGE or DONE.
- IDLE:
  - item_sel in 1..N_ITEMS with stock>0 -> COLLECT. Latch item; qty = min(qty_sel or 1, stock); price_due = PRICE[item]*qty.
  - Selection of an item whose stock is 0: sold_out pulse, stay in IDLE.
  - cancel with collected>0 -> CHANGE, change=collected. restock applies only here.
- COLLECT:
  - qty_sel nonzero updates qty (clamped to stock) and price_due each cycle.
  - If collected >= price_due -> VEND.
  - cancel -> CHANGE with change=collected; a coin in the same cycle is credited first and included in the refund.
  - Inactivity counter cleared by every credited coin. At TIMEOUT: timeout_flag pulse, refund as cancel; with zero credit go straight to IDLE.
- VEND (1 cycle):
  - deliver_valid pulse with item/qty; stock[item] -= qty; change = collected - price_due; collected = 0.
  - Next state: CHANGE if change>0, else DONE.
  - cancel is ignored from VEND onward.
- CHANGE:
  - Each cycle emit the largest coin <= change (100, 25, 10, 5) and subtract it.
  - When change reaches 0: go to DONE after a purchase, or IDLE after a refund.
  - Credit is always a multiple of 5, so change never leaves a remainder.
- DONE: cont -> IDLE, clears price_due and the latched item.
- Width rule: price*qty is computed in AMT_W. Default prices must keep price*max_qty < 2^AMT_W; this is statically checked by an assertion.

Decomposition:
- Package vend_pkg:
  - state enum.
  - Coin code localparams and values (5/10/25/100).
  - PRICE array for the defaults: 50,80,100,120,150,60,90,200.
  - Function coin_value().
- Sub-module vend_change_disp: loads an amount, emits greedy coin pulses, and raises done.

Test Plan:
1. Reset; select item 2, qty 0; coins quarter x3 + dime -> collected 85, deliver_valid item2 qty1, one change pulse (nickel), DONE; cont -> IDLE, stock[2]=3.
2. Select item 1; quarter + dime; cancel -> change quarter then dime on consecutive cycles, IDLE, no deliver_valid.
3. Select item 5, qty 2 -> price_due 300; three dollars -> deliver qty2, no change pulses; stock[5]=2.
4. Five dollars in IDLE then a dime -> collected stays 500, coin_reject pulse.
5. Buy item 3 four times until stock is 0; select item 3 again -> sold_out pulse, stay IDLE; restock -> stock 4.
6. Select item 8, insert a dime, wait TIMEOUT cycles -> timeout_flag, one dime change pulse, IDLE. Separately, assert rst during CHANGE -> IDLE, no further change pulses.
